synchronous_fifo_memory: RTL and testbench
==========================================

SYNCHRONOUS_FIFO_MEMORY -- requirements
Module: synchronous_fifo_memory

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 5, bits per entry; DEPTH, default 8, number of entries (power of two); ADDR_WIDTH, default 3, log2(DEPTH).
REQ-002 Port clk SHALL be an input, width 1: the single clock; all state changes on its rising edge.
REQ-003 Port n_rst SHALL be an input, width 1: reset, asynchronous and active-low.
REQ-004 Port write_rq SHALL be an input, width 1: write request, sampled on the rising edge of clk.
REQ-005 Port read_rq SHALL be an input, width 1: read request, sampled on the rising edge of clk.
REQ-006 Port data_in SHALL be an input, width DATA_WIDTH: write data, sampled when a write is accepted.
REQ-007 Port empty SHALL be an output, width 1: high when count == 0.
REQ-008 Port almost_empty SHALL be an output, width 1: high when count == 1.
REQ-009 Port almost_full SHALL be an output, width 1: high when count == DEPTH-1.
REQ-010 Port full SHALL be an output, width 1: high when count == DEPTH.
REQ-011 Port data_out SHALL be an output, width DATA_WIDTH: registered read data.

Function
REQ-012 The block SHALL hold DEPTH entries of DATA_WIDTH bits with a write pointer, a read pointer (ADDR_WIDTH bits each, wrapping DEPTH-1 -> 0) and an occupancy count (ADDR_WIDTH+1 bits, range 0..DEPTH).
REQ-013 Write accept SHALL be write_rq && (!full || read accepted this edge): data_in is stored at the write pointer and the write pointer increments.
REQ-014 Read accept SHALL be read_rq && !empty: data_out loads the entry at the read pointer on that same edge (1-cycle latency; data valid after the edge), and the read pointer increments.
REQ-015 When no read is accepted, data_out SHALL hold its previous value.
REQ-016 A write while full with no accepted read SHALL be ignored; memory, pointers and count are unchanged (no overflow).
REQ-017 A read while empty SHALL be ignored; pointers, count and data_out are unchanged (no underflow).
REQ-018 Simultaneous write and read while not empty SHALL both be performed and leave count unchanged; this includes the full state.
REQ-019 Simultaneous write and read while empty SHALL perform only the write (count 0 -> 1); data is not passed through to data_out.
REQ-020 Count SHALL be +1 on write-only, -1 on read-only, and unchanged otherwise.
REQ-021 Status flags SHALL be combinational decodes of the registered count, valid in the same cycle the count changes.
REQ-022 FIFO ordering SHALL be strictly first-in first-out across pointer wrap-around.

Reset
REQ-023 While n_rst is low, asynchronously and independent of clk: pointers = 0, count = 0, data_out = 0, empty = 1, almost_empty = 0, almost_full = 0, full = 0.
REQ-024 Requests SHALL be ignored while n_rst is low; reset mid-operation SHALL discard all stored entries.
REQ-025 Memory contents SHALL NOT require reset.
REQ-026 Operation SHALL resume on the first rising edge after n_rst deasserts.

Verification
REQ-027 Reset with write_rq=1 held for 2 edges -> empty=1, data_out=0, count stays 0.
REQ-028 Write 0, 1, 2 on consecutive edges -> after the 1st write almost_empty=1; after the 3rd write empty=0, almost_empty=0; then read -> data_out=0.
REQ-029 Simultaneous write of 3 and read with 2 entries held -> data_out=1 and count unchanged (2); two further reads -> data_out=2 then 3, and empty=1.
REQ-030 Write 25 into the empty FIFO, read -> data_out=25; a further read on empty -> data_out holds 25 and the flags are unchanged.
REQ-031 Fill with 8 writes -> almost_full=1 after the 7th write, full=1 after the 8th; a 9th write is ignored; 8 reads return the data in order across the pointer wrap.
REQ-032 When full, simultaneous write and read -> full stays 1 and the oldest entry is output; assert n_rst low mid-stream -> all flags and data_out immediately take their reset values.

Source files
------------

// File: rtl/synchronous_fifo_memory.sv
// Single-clock FIFO: DEPTH x DATA_WIDTH storage, registered read port,
// occupancy counter and status flags decoded from that counter.
module synchronous_fifo_memory #(
    parameter int DATA_WIDTH = 5,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  write_rq,
    input  logic                  read_rq,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam logic [ADDR_WIDTH:0]   L_COUNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   L_COUNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] L_PTR_ONE    = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_data_out;

    logic                  w_rd_accept;
    logic                  w_wr_accept;
    logic [ADDR_WIDTH:0]   w_count_next;

    // A full FIFO can still take a write when a read frees a slot on the same edge.
    assign w_rd_accept = read_rq && !empty;
    assign w_wr_accept = write_rq && (!full || w_rd_accept);

    always_comb begin
        w_count_next = r_count;
        case ({w_wr_accept, w_rd_accept})
            2'b10:   w_count_next = r_count + L_COUNT_ONE;
            2'b01:   w_count_next = r_count - L_COUNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_wr_accept && n_rst) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data_out <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
            end
            if (w_rd_accept) begin
                r_rd_ptr   <= r_rd_ptr + L_PTR_ONE;
                r_data_out <= r_mem[r_rd_ptr];
            end
            r_count <= w_count_next;
        end
    end

    assign empty        = (r_count == '0);
    assign almost_empty = (r_count == L_COUNT_ONE);
    assign almost_full  = (r_count == (L_COUNT_FULL - L_COUNT_ONE));
    assign full         = (r_count == L_COUNT_FULL);
    assign data_out     = r_data_out;

endmodule

// File: tb/tb_synchronous_fifo_memory.sv
// Directed bench for synchronous_fifo_memory: stimulus pushes expected
// post-edge state into a queue, a monitor pops and compares it.
module tb_synchronous_fifo_memory;

    localparam int DW = 5;

    logic          clk;
    logic          n_rst;
    logic          write_rq;
    logic          read_rq;
    logic [DW-1:0] data_in;
    logic          empty;
    logic          almost_empty;
    logic          almost_full;
    logic          full;
    logic [DW-1:0] data_out;

    typedef struct {
        logic [DW-1:0] dout;
        logic [3:0]    flags;  // {empty, almost_empty, almost_full, full}
        string         name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    event chk_ev;

    localparam logic [3:0] F_E  = 4'b1000;
    localparam logic [3:0] F_AE = 4'b0100;
    localparam logic [3:0] F_MID = 4'b0000;
    localparam logic [3:0] F_AF = 4'b0010;
    localparam logic [3:0] F_F  = 4'b0001;

    synchronous_fifo_memory #(
        .DATA_WIDTH(DW),
        .DEPTH     (8),
        .ADDR_WIDTH(3)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .write_rq    (write_rq),
        .read_rq     (read_rq),
        .data_in     (data_in),
        .empty       (empty),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .full        (full),
        .data_out    (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expectation per clock edge, or immediately on chk_ev.
    initial begin
        exp_t       e;
        logic [3:0] act_flags;
        forever begin
            @(posedge clk or chk_ev);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act_flags = {empty, almost_empty, almost_full, full};
                checks++;
                if (data_out !== e.dout || act_flags !== e.flags) begin
                    errors++;
                    $display("FAIL %s: data_out=%0d flags=%b, required data_out=%0d flags=%b",
                             e.name, data_out, act_flags, e.dout, e.flags);
                end else begin
                    $display("ok   %s: data_out=%0d flags=%b", e.name, data_out, act_flags);
                end
            end
        end
    end

    task automatic step(input logic rst_v, input logic w, input logic r,
                        input logic [DW-1:0] d, input logic [DW-1:0] exp_do,
                        input logic [3:0] exp_fl, input string name);
        exp_t e;
        @(negedge clk);
        n_rst    = rst_v;
        write_rq = w;
        read_rq  = r;
        data_in  = d;
        e.dout  = exp_do;
        e.flags = exp_fl;
        e.name  = name;
        exp_q.push_back(e);
    endtask

    // Pull reset low between edges and check the outputs before any clock edge.
    task automatic async_reset_check(input string name);
        exp_t e;
        @(negedge clk);
        #1;
        n_rst    = 1'b0;
        write_rq = 1'b0;
        read_rq  = 1'b1;
        e.dout  = '0;
        e.flags = F_E;
        e.name  = name;
        exp_q.push_back(e);
        ->chk_ev;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst    = 1'b0;
        write_rq = 1'b0;
        read_rq  = 1'b0;
        data_in  = '0;

        // Reset held with write requests asserted.
        step(0, 1, 0, 5'd7, 5'd0, F_E,  "rst_wr_edge1");
        step(0, 1, 0, 5'd7, 5'd0, F_E,  "rst_wr_edge2");
        step(1, 0, 0, 5'd0, 5'd0, F_E,  "rst_release");

        // Write 0,1,2 then read.
        step(1, 1, 0, 5'd0, 5'd0, F_AE,  "wr0");
        step(1, 1, 0, 5'd1, 5'd0, F_MID, "wr1");
        step(1, 1, 0, 5'd2, 5'd0, F_MID, "wr2");
        step(1, 0, 1, 5'd0, 5'd0, F_MID, "rd_0");

        // Simultaneous write/read with two entries held.
        step(1, 1, 1, 5'd3, 5'd1, F_MID, "wr3_rd_1");
        step(1, 0, 1, 5'd0, 5'd2, F_AE,  "rd_2");
        step(1, 0, 1, 5'd0, 5'd3, F_E,   "rd_3");

        // Single entry, then read on empty holds data.
        step(1, 1, 0, 5'd25, 5'd3,  F_AE, "wr25");
        step(1, 0, 1, 5'd0,  5'd25, F_E,  "rd_25");
        step(1, 0, 1, 5'd0,  5'd25, F_E,  "rd_empty_hold");

        // Write and read together while empty: only the write happens.
        step(1, 1, 1, 5'd9, 5'd25, F_AE, "wr_rd_on_empty");
        step(1, 0, 1, 5'd0, 5'd9,  F_E,  "rd_9");

        // Fill across pointer wrap (pointers start at 6 here).
        for (int i = 0; i < 8; i++) begin
            logic [3:0] fl;
            fl = (i == 0) ? F_AE : (i == 6) ? F_AF : (i == 7) ? F_F : F_MID;
            step(1, 1, 0, 5'(10 + i), 5'd9, fl, $sformatf("fill_%0d", i));
        end
        step(1, 1, 0, 5'd30, 5'd9, F_F, "wr_ignored_full");

        for (int i = 0; i < 8; i++) begin
            logic [3:0] fl;
            fl = (i == 0) ? F_AF : (i == 6) ? F_AE : (i == 7) ? F_E : F_MID;
            step(1, 0, 1, 5'd0, 5'(10 + i), fl, $sformatf("drain_%0d", i));
        end

        // Refill, then write+read while full.
        for (int i = 0; i < 8; i++) begin
            logic [3:0] fl;
            fl = (i == 0) ? F_AE : (i == 6) ? F_AF : (i == 7) ? F_F : F_MID;
            step(1, 1, 0, 5'(20 + i), 5'd17, fl, $sformatf("refill_%0d", i));
        end
        step(1, 1, 1, 5'd28, 5'd20, F_F,   "wr_rd_full");
        step(1, 0, 1, 5'd0,  5'd21, F_AF,  "rd_21");
        step(1, 0, 1, 5'd0,  5'd22, F_MID, "rd_22");

        // Reset in the middle of traffic.
        async_reset_check("async_reset");
        step(0, 1, 1, 5'd4, 5'd0, F_E, "rst_held_req");
        step(1, 0, 1, 5'd0, 5'd0, F_E, "rd_after_reset");
        step(1, 1, 0, 5'd5, 5'd0, F_AE, "wr5_after_reset");
        step(1, 0, 1, 5'd0, 5'd5, F_E,  "rd_5");

        @(negedge clk);
        write_rq = 1'b0;
        read_rq  = 1'b0;
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
